// File: rtl/psum_ofifo.sv
// Output FIFO for a systolic MAC array: one FWFT lane per column, written with
// skewed per-column valids and popped a full row at a time.
module psum_ofifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [col*psum_bw-1:0]   in,
    input  logic [col-1:0]           wr,
    input  logic                     rd,
    output logic [col*psum_bw-1:0]   out,
    output logic                     o_valid,
    output logic                     o_full,
    output logic                     o_ready,
    output logic                     o_overflow
);

    localparam int AW = $clog2(depth);

    logic [AW:0]          r_wptr [col];
    logic [AW:0]          r_rptr [col];
    logic [psum_bw-1:0]   r_mem  [col][depth];
    logic                 r_overflow;

    logic [col-1:0]       w_empty;
    logic [col-1:0]       w_full;
    logic [col-1:0]       w_wen;
    logic [col-1:0]       w_drop;
    logic                 w_pop;

    // Pointer MSB is the wrap bit: equal pointers mean empty, equal low bits
    // with differing wrap bits mean full.
    always_comb begin
        w_empty = '0;
        w_full  = '0;
        for (int c = 0; c < col; c++) begin
            w_empty[c] = (r_wptr[c] == r_rptr[c]);
            w_full[c]  = (r_wptr[c][AW-1:0] == r_rptr[c][AW-1:0]) &&
                         (r_wptr[c][AW] != r_rptr[c][AW]);
        end
    end

    assign o_valid    = &(~w_empty);
    assign o_full     = |w_full;
    assign o_ready    = ~o_full;
    assign o_overflow = r_overflow;
    assign w_pop      = rd & o_valid;

    // A full lane still accepts a write when the row pop frees its head slot.
    assign w_wen  = wr & (~w_full | {col{w_pop}});
    assign w_drop = wr & w_full & {col{~w_pop}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < col; c++) begin
                r_wptr[c] <= '0;
                r_rptr[c] <= '0;
            end
            r_overflow <= 1'b0;
        end else begin
            for (int c = 0; c < col; c++) begin
                if (w_wen[c]) begin
                    r_wptr[c] <= r_wptr[c] + (AW+1)'(1);
                end
                if (w_pop) begin
                    r_rptr[c] <= r_rptr[c] + (AW+1)'(1);
                end
            end
            if (|w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < col; c++) begin
            if (w_wen[c]) begin
                r_mem[c][r_wptr[c][AW-1:0]] <= in[c*psum_bw +: psum_bw];
            end
        end
    end

    always_comb begin
        out = '0;
        for (int c = 0; c < col; c++) begin
            out[c*psum_bw +: psum_bw] = r_mem[c][r_rptr[c][AW-1:0]];
        end
    end

endmodule

// File: tb/tb_psum_ofifo.sv
// Scoreboard bench for psum_ofifo: stimulus queues expected rows, a monitor
// compares every popped row; flag checks are done inline after each edge.
module tb_psum_ofifo;

    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int DEP = 64;
    localparam int W   = COL*BW;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   in;
    logic [COL-1:0] wr;
    logic           rd;
    logic [W-1:0]   out;
    logic           o_valid, o_full, o_ready, o_overflow;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] expQ [$];
    bit sawFull;

    psum_ofifo #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
        .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .out(out),
        .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready),
        .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rowOf(input int base, input int step);
        logic [W-1:0] r;
        r = '0;
        for (int c = 0; c < COL; c++) r[c*BW +: BW] = BW'(base + step*c);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] act,
                               input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [COL-1:0] w, input logic [W-1:0] d,
                                 input logic r);
        wr = w;
        in = d;
        rd = r;
        tick();
    endtask

    // Monitor: a row is consumed on the next edge whenever rd and o_valid are both high.
    always @(negedge clk) begin
        if (reset && rd && o_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_pop", out, '0);
                if (out === '0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpected_pop: got pop, expected none");
                end
            end else begin
                checkOutput("pop_row", out, expQ.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0; wr = '0; rd = 1'b0; in = '0;
        tick(); tick();
        checkOutput("reset_valid", W'(o_valid), W'(0));
        checkOutput("reset_full", W'(o_full), W'(0));
        checkOutput("reset_ready", W'(o_ready), W'(1));
        checkOutput("reset_ovf", W'(o_overflow), W'(0));
        reset = 1'b1;
        tick();

        // Single skewed row: lane c gets c+1 on cycle c.
        for (int c = 0; c < COL; c++) begin
            applyStimulus(COL'(1) << c, rowOf(1, 1), 1'b0);
            checkOutput($sformatf("skew_valid_%0d", c), W'(o_valid), W'(c == COL-1));
        end
        expQ.push_back(rowOf(1, 1));
        applyStimulus('0, '0, 1'b1);
        rd = 1'b0;
        checkOutput("skew_after_pop_valid", W'(o_valid), W'(0));

        // rd while lane 7 is empty must not move any pointer.
        applyStimulus(8'h7F, rowOf(10, 1), 1'b0);
        applyStimulus('0, '0, 1'b1);
        applyStimulus('0, '0, 1'b1);
        checkOutput("partial_valid", W'(o_valid), W'(0));
        applyStimulus(8'h80, rowOf(10, 1), 1'b0);
        checkOutput("partial_lane7_valid", W'(o_valid), W'(1));
        expQ.push_back(rowOf(10, 1));
        applyStimulus('0, '0, 1'b1);
        rd = 1'b0;
        checkOutput("partial_after_pop", W'(o_valid), W'(0));

        // Fill to full with rows 0..63.
        for (int r = 0; r < DEP; r++) begin
            applyStimulus('1, rowOf(r, 0), 1'b0);
            expQ.push_back(rowOf(r, 0));
            if (r == DEP-2) checkOutput("fill63_full", W'(o_full), W'(0));
        end
        checkOutput("fill_full", W'(o_full), W'(1));
        checkOutput("fill_ready", W'(o_ready), W'(0));
        checkOutput("fill_ovf", W'(o_overflow), W'(0));

        // Write while full with a concurrent pop is accepted.
        expQ.push_back(rowOf(99, 0));
        applyStimulus('1, rowOf(99, 0), 1'b1);
        checkOutput("fullpop_full", W'(o_full), W'(1));
        checkOutput("fullpop_ovf", W'(o_overflow), W'(0));

        // Write to a full lane without pop is dropped.
        applyStimulus(8'h01, rowOf(77, 0), 1'b0);
        checkOutput("drop_ovf", W'(o_overflow), W'(1));
        checkOutput("drop_full", W'(o_full), W'(1));

        for (int r = 0; r < DEP; r++) applyStimulus('0, '0, 1'b1);
        rd = 1'b0;
        checkOutput("drain_valid", W'(o_valid), W'(0));
        checkOutput("drain_full", W'(o_full), W'(0));
        checkOutput("drain_ovf_sticky", W'(o_overflow), W'(1));
        checkOutput("drain_queue_empty", W'(expQ.size()), W'(0));

        // Stream 200 rows with concurrent pops across many pointer wraps.
        sawFull = 1'b0;
        for (int i = 0; i < 200; i++) begin
            expQ.push_back(rowOf(i*8, 1));
            applyStimulus('1, rowOf(i*8, 1), i != 0);
            if (o_full) sawFull = 1'b1;
        end
        applyStimulus('0, '0, 1'b1);
        rd = 1'b0;
        checkOutput("stream_never_full", W'(sawFull), W'(0));
        checkOutput("stream_valid_end", W'(o_valid), W'(0));
        checkOutput("stream_queue_empty", W'(expQ.size()), W'(0));

        // Async reset between edges with 5 rows queued (those rows are discarded).
        for (int r = 0; r < 5; r++) applyStimulus('1, rowOf(500 + r, 2), 1'b0);
        wr = '0;
        checkOutput("pre_reset_valid", W'(o_valid), W'(1));
        reset = 1'b0;
        #1;
        checkOutput("async_valid", W'(o_valid), W'(0));
        checkOutput("async_ovf", W'(o_overflow), W'(0));
        checkOutput("async_ready", W'(o_ready), W'(1));
        #1;
        reset = 1'b1;
        expQ.push_back(rowOf(700, 3));
        applyStimulus('1, rowOf(700, 3), 1'b0);
        checkOutput("post_reset_valid", W'(o_valid), W'(1));
        applyStimulus('0, '0, 1'b1);
        rd = 1'b0;
        checkOutput("post_reset_empty", W'(o_valid), W'(0));
        checkOutput("final_queue_empty", W'(expQ.size()), W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/psum_ofifo.md
PSUM_OFIFO -- requirements
Module: psum_ofifo

Interface
REQ-001 SHALL have parameter col, default 8, meaning the number of MAC array columns and per-column FIFO lanes.
REQ-002 SHALL have parameter psum_bw, default 16, meaning the partial-sum width per column.
REQ-003 SHALL have parameter depth, default 64, meaning the entries per lane; it is a power of two and at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset; low clears all state immediately.
REQ-006 SHALL have port in, input, col*psum_bw bits: column psums from the array's south edge; lane c is bits [(c+1)*psum_bw-1 : c*psum_bw].
REQ-007 SHALL have port wr, input, col bits: per-lane write strobe, driven by the array's per-column valid.
REQ-008 SHALL have port rd, input, 1 bit: pop request for one full row, all lanes together.
REQ-009 SHALL have port out, output, col*psum_bw bits: head entry of every lane, first-word-fall-through, same lane packing as in.
REQ-010 SHALL have port o_valid, output, 1 bit: high when every lane is non-empty.
REQ-011 SHALL have port o_full, output, 1 bit: high when any lane is full.
REQ-012 SHALL have port o_ready, output, 1 bit: high when no lane is full (the inverse of o_full).
REQ-013 SHALL have port o_overflow, output, 1 bit: sticky flag, set when a write is dropped.

Function
REQ-014 SHALL give each lane independent write and read pointers of log2(depth)+1 bits (MSB is the wrap bit), plus depth x psum_bw storage.
REQ-015 SHALL define lane empty as: pointers equal. Lane full as: low bits equal and wrap bits differ.
REQ-016 SHALL, on a rising edge with wr[c]=1 and lane c not full, store in lane c at the write pointer and increment the write pointer modulo 2*depth.
REQ-017 SHALL pop when rd=1 and o_valid=1: every lane's read pointer increments by one on that edge.
REQ-018 SHALL ignore rd when o_valid=0: no pointer moves, and no error is flagged.
REQ-019 SHALL drop a write when wr[c]=1 and lane c is full and no pop occurs that cycle; storage and pointers stay unchanged and o_overflow sets to 1.
REQ-020 SHALL accept the write when wr[c]=1, lane c is full and a pop occurs in the same cycle; the occupancy of lane c stays at depth.
REQ-021 SHALL, on simultaneous write and pop on a lane holding exactly 1 entry, leave that lane holding the newly written entry.
REQ-022 SHALL make write-to-out latency one cycle: a word written into an empty lane at edge N appears on out at edge N (after the register update), and o_valid rises after edge N if all other lanes are non-empty.
REQ-023 SHALL drive out lane c combinationally from the storage at lane c's read pointer; its value while lane c is empty is don't-care.
REQ-024 SHALL derive o_valid, o_full and o_ready combinationally from the pointers, with no added latency.
REQ-025 SHALL handle lanes written on different cycles (skewed diagonal valids), aligning the rows by per-lane ordering only; no data reordering occurs within a lane.
REQ-026 SHALL wrap pointers silently; order and data SHALL be preserved across wrap-around for any number of passes.
REQ-027 SHALL keep o_overflow set until reset.

Reset
REQ-028 SHALL, while reset=0, clear all pointers and o_overflow asynchronously, giving o_valid=0, o_full=0 and o_ready=1; storage contents are not reset.
REQ-029 SHALL discard any in-flight row on reset mid-operation; the first edge after reset deasserts SHALL treat wr and rd normally.

Verification
REQ-030 SHALL pass single row: col=8, write lane c=c+1 on cycle c (skewed), then rd=1 -> o_valid rises only after lane 7 is written; out = {8,7,...,1}; after the pop, o_valid=0.
REQ-031 SHALL pass fill to full: 64 rows written with rd=0 -> o_full=1 and o_ready=0 after the 64th; a 65th write to lane 0 -> dropped and o_overflow=1; popping 64 rows returns the values 0..63 in order.
REQ-032 SHALL pass full with simultaneous pop: all lanes full, wr=all-ones with value 99 and rd=1 -> one row popped, 99 enqueued, o_full stays 1, o_overflow stays 0.
REQ-033 SHALL pass rd on partial data: lanes 0-6 written, lane 7 empty, rd=1 -> no pointer moves; lane 7 is written next -> o_valid=1 with lanes 0-6 data unchanged.
REQ-034 SHALL pass wrap-around: 200 rows streamed with concurrent pops (occupancy at most 3) -> all 200 rows out in order; o_full never asserts.
REQ-035 SHALL pass async reset mid-stream: reset=0 pulsed between edges with 5 rows queued -> o_valid=0 immediately and o_overflow=0; a new write afterwards is read back correctly.
